mips_bus_arbiter: RTL

Two-master, one-slave arbiter that shares the single Avalon-style memory bus of the MIPS CPU between the instruction-fetch master (M0) and the load/store master (M1). It sits between `mips_cpu_bus` internals and the memory (`mips_cpu_mock_mem` in simulation). It grants the bus round-robin and locks each grant until the slave completes the transfer. It also monitors slave stalls and raises a sticky timeout flag.

---
 rtl/mips_bus_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mips_bus_arbiter.sv
// Two-master / one-slave Avalon-style bus arbiter for the MIPS CPU.
// M0 = instruction fetch, M1 = load/store. Round-robin on ties, each grant
// is held until the slave completes the transfer or the master abandons it.
// A stall counter flags slaves that hold waitrequest for too long.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | nobody owns the bus, slave outputs parked at 0
// GNT0   | M0 owns the bus, slave side mirrors M0
// GNT1   | M1 owns the bus, slave side mirrors M1
module mips_bus_arbiter #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic [31:0] m0_readdata,
  output logic        m0_waitrequest,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic [31:0] m1_readdata,
  output logic        m1_waitrequest,
  output logic        read,
  output logic        write,
  output logic [31:0] address,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2
  } state_t;

  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);
  localparam logic [15:0] LP_CNT_MAX = 16'hFFFF;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;          // 0 = M0 granted most recently, 1 = M1
  logic        w_last_nxt;
  logic [15:0] r_stall_cnt;
  logic [15:0] w_stall_cnt_nxt;
  logic        r_timeout_err;
  logic        w_timeout_nxt;
  logic [1:0]  r_grant;

  logic        w_m0_req;
  logic        w_m1_req;
  logic [15:0] w_stall_inc;

  assign w_m0_req    = m0_read | m0_write;
  assign w_m1_req    = m1_read | m1_write;
  assign w_stall_inc = (r_stall_cnt == LP_CNT_MAX) ? r_stall_cnt : r_stall_cnt + 16'd1;

  assign grant       = r_grant;
  assign timeout_err = r_timeout_err;

  // State, round-robin pointer, stall counter and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_last        <= 1'b1;
      r_stall_cnt   <= '0;
      r_timeout_err <= 1'b0;
      r_grant       <= 2'b00;
    end else begin
      r_state       <= w_state_nxt;
      r_last        <= w_last_nxt;
      r_stall_cnt   <= w_stall_cnt_nxt;
      r_timeout_err <= w_timeout_nxt;
      r_grant       <= {w_state_nxt == S_GNT1, w_state_nxt == S_GNT0};
    end
  end

  // Next-state: arbitration in IDLE, completion/handoff/abandon in GNTx.
  // The stall counter only survives an edge that keeps the same owner stalled;
  // every other edge (entry, completion, abandon, idle) leaves it at zero.
  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_stall_cnt_nxt = '0;
    w_timeout_nxt   = r_timeout_err;
    case (r_state)
      S_IDLE: begin
        if (w_m0_req && w_m1_req) begin
          w_state_nxt = r_last ? S_GNT0 : S_GNT1;
          w_last_nxt  = ~r_last;
        end else if (w_m0_req) begin
          w_state_nxt = S_GNT0;
          w_last_nxt  = 1'b0;
        end else if (w_m1_req) begin
          w_state_nxt = S_GNT1;
          w_last_nxt  = 1'b1;
        end
      end
      S_GNT0: begin
        if (!w_m0_req) begin
          w_state_nxt = S_IDLE;
        end else if (!waitrequest) begin
          if (w_m1_req) begin
            w_state_nxt = S_GNT1;
            w_last_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_stall_cnt_nxt = w_stall_inc;
          if (w_stall_inc >= LP_TIMEOUT) w_timeout_nxt = 1'b1;
        end
      end
      S_GNT1: begin
        if (!w_m1_req) begin
          w_state_nxt = S_IDLE;
        end else if (!waitrequest) begin
          if (w_m0_req) begin
            w_state_nxt = S_GNT0;
            w_last_nxt  = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_stall_cnt_nxt = w_stall_inc;
          if (w_stall_inc >= LP_TIMEOUT) w_timeout_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus steering: the owner is mirrored to the slave, everyone else stalls.
  // A simultaneous read+write is forwarded as a write only.
  always_comb begin
    read           = 1'b0;
    write          = 1'b0;
    address        = '0;
    writedata      = '0;
    byteenable     = '0;
    m0_readdata    = '0;
    m1_readdata    = '0;
    m0_waitrequest = w_m0_req;
    m1_waitrequest = w_m1_req;
    case (r_state)
      S_GNT0: begin
        read           = m0_read & ~m0_write;
        write          = m0_write;
        address        = m0_address;
        writedata      = m0_writedata;
        byteenable     = m0_byteenable;
        m0_readdata    = readdata;
        m0_waitrequest = waitrequest;
      end
      S_GNT1: begin
        read           = m1_read & ~m1_write;
        write          = m1_write;
        address        = m1_address;
        writedata      = m1_writedata;
        byteenable     = m1_byteenable;
        m1_readdata    = readdata;
        m1_waitrequest = waitrequest;
      end
      default: ;
    endcase
  end

endmodule
